// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: access-size codes,
// FSM state encoding and the per-size lane mask helper.
package lsu_pkg;

   localparam int WORD_BYTES = 8;
   localparam int OFF_BITS   = 3;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef logic [2:0] lsu_state_t;

   localparam lsu_state_t ST_IDLE = 3'd0;
   localparam lsu_state_t ST_RD   = 3'd1;
   localparam lsu_state_t ST_CAP  = 3'd2;
   localparam lsu_state_t ST_WR   = 3'd3;
   localparam lsu_state_t ST_RESP = 3'd4;

   function automatic logic [63:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    size_mask = 64'h0000_0000_0000_00FF;
         SZ_H:    size_mask = 64'h0000_0000_0000_FFFF;
         SZ_W:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment detect on the incoming request,
// sub-word load extract/extend and sub-word store merge on the latched request.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]          chk_size,
   input  logic [OFF_BITS-1:0] chk_off,
   output logic                misaligned,
   input  logic [1:0]          size,
   input  logic [OFF_BITS-1:0] off,
   input  logic                is_unsigned,
   input  logic [63:0]         rdata,
   input  logic [63:0]         wdata,
   output logic [63:0]         load_data,
   output logic [63:0]         merged
);

   logic [5:0]  shamt;
   logic [63:0] lane;
   logic [63:0] mask;
   logic        sx;

   always_comb begin
      case (chk_size)
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = chk_off[0];
         SZ_W:    misaligned = |chk_off[1:0];
         default: misaligned = |chk_off;
      endcase
   end

   assign shamt = {off, 3'b000};
   assign lane  = rdata >> shamt;
   assign mask  = size_mask(size);
   assign sx    = ~is_unsigned;

   // Dword loads return the lane as-is, so req_unsigned has no effect there.
   always_comb begin
      case (size)
         SZ_B:    load_data = {{56{sx & lane[7]}},  lane[7:0]};
         SZ_H:    load_data = {{48{sx & lane[15]}}, lane[15:0]};
         SZ_W:    load_data = {{32{sx & lane[31]}}, lane[31:0]};
         default: load_data = lane;
      endcase
   end

   assign merged = (rdata & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time against a 64-bit word memory with
// 1-cycle registered reads. Optional range check via LSU_BOUNDS_CHECK_EN.
module lsu
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 1024
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_rdata,
   output lsu_state_t  dbg_state
);

   localparam int AW = $clog2(MEM_WORDS);

   lsu_state_t          state;
   logic                write_q;
   logic [1:0]          size_q;
   logic [OFF_BITS-1:0] off_q;
   logic                unsigned_q;
   logic [63:0]         wdata_q;
   logic                misaligned;
   logic                out_of_range;
   logic [63:0]         load_data;
   logic [63:0]         merged;

`ifdef LSU_BOUNDS_CHECK_EN
   assign out_of_range = |req_addr[63:OFF_BITS+AW];
`else
   // Upper address bits are dropped: the word index wraps modulo MEM_WORDS.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[63:OFF_BITS+AW];
   assign out_of_range   = 1'b0;
`endif

   lsu_align u_align (
      .chk_size    (req_size),
      .chk_off     (req_addr[OFF_BITS-1:0]),
      .misaligned  (misaligned),
      .size        (size_q),
      .off         (off_q),
      .is_unsigned (unsigned_q),
      .rdata       (mem_rdata),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged      (merged)
   );

   // Handshake: a request is taken on an edge with req_valid && req_ready;
   // req_ready is high only in IDLE, and every request yields exactly one
   // single-cycle resp_valid pulse with resp_err qualified by it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         write_q    <= 1'b0;
         size_q     <= SZ_B;
         off_q      <= '0;
         unsigned_q <= 1'b0;
         wdata_q    <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  write_q    <= req_write;
                  size_q     <= req_size;
                  off_q      <= req_addr[OFF_BITS-1:0];
                  unsigned_q <= req_unsigned;
                  wdata_q    <= req_wdata;
                  mem_addr   <= 64'(req_addr[OFF_BITS +: AW]);
                  resp_err   <= misaligned | out_of_range;
                  if (misaligned || out_of_range) begin
                     state <= ST_RESP;
                  end else if (req_write && req_size == SZ_D) begin
                     mem_wdata <= req_wdata;
                     state     <= ST_WR;
                  end else begin
                     state <= ST_RD;
                  end
               end
            end
            ST_RD: state <= ST_CAP;
            ST_CAP: begin
               if (write_q) begin
                  mem_wdata <= merged;
                  state     <= ST_WR;
               end else begin
                  resp_rdata <= load_data;
                  state      <= ST_RESP;
               end
            end
            ST_WR:   state <= ST_RESP;
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign mem_read   = (state == ST_RD);
   assign mem_write  = (state == ST_WR);
   assign resp_valid = (state == ST_RESP);
   assign dbg_state  = state;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized requests checked against
// a byte-level reference memory model; the bench also plays the data memory.
module tb_lsu;
   import lsu_pkg::*;

   localparam int MEM_WORDS = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [63:0] mem_rdata;
   lsu_state_t  dbg_state;

   logic [63:0] tb_mem  [MEM_WORDS];
   logic [63:0] ref_mem [MEM_WORDS];
   logic [63:0] exp_rdata;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   lsu #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_write    (mem_write),
      .mem_read     (mem_read),
      .mem_rdata    (mem_rdata),
      .dbg_state    (dbg_state)
   );

   // Data memory: registered read, write on clk.
   always @(posedge clk) begin
      if (mem_read)  mem_rdata <= tb_mem[mem_addr[9:0]];
      if (mem_write) tb_mem[mem_addr[9:0]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [63:0] val);
      tb_mem[idx]  = val;
      ref_mem[idx] = val;
   endtask

   task automatic run_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata);
      int          nbytes, off, idx, exp_lat, exp_rd, exp_wr;
      int          lat, n_rd, n_wr, n_resp, n_both;
      logic        err, oor;
      logic [63:0] word, val, mask, rd_addr, wr_addr, wr_data, rdata_seen, err_seen;
      nbytes = 1 << size;
      off    = int'(addr[2:0]);
      idx    = int'((addr >> 3) % MEM_WORDS);
      oor    = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
      oor    = (addr >> 3) >= MEM_WORDS;
`endif
      err    = ((off % nbytes) != 0) || oor;
      word   = ref_mem[idx];
      if (err) begin
         exp_lat = 1; exp_rd = 0; exp_wr = 0;
      end else if (!wr) begin
         exp_lat = 3; exp_rd = 1; exp_wr = 0;
         val = word >> (8 * off);
         if (nbytes < 8) begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            val  = val & mask;
            if (!uns && val[8*nbytes-1]) val = val | ~mask;
         end
         exp_rdata = val;
      end else if (nbytes == 8) begin
         exp_lat = 2; exp_rd = 0; exp_wr = 1;
         word = wdata;
      end else begin
         exp_lat = 4; exp_rd = 1; exp_wr = 1;
         for (int b = 0; b < nbytes; b++) word[8*(off+b) +: 8] = wdata[8*b +: 8];
      end

      @(negedge clk);
      check("ready_before_req", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_write = wr; req_size = size;
      req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'($urandom); req_size = 2'($urandom);
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

      lat = 0; n_rd = 0; n_wr = 0; n_resp = 0; n_both = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0; rdata_seen = '0; err_seen = '0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (mem_read)  begin n_rd++; rd_addr = mem_addr; end
         if (mem_write) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
         if (mem_read && mem_write) n_both++;
         if (resp_valid) begin
            n_resp++; lat = c; err_seen = 64'(resp_err); rdata_seen = resp_rdata;
         end
      end

      check("resp_count",   64'(n_resp), 64'd1);
      check("resp_latency", 64'(lat),    64'(exp_lat));
      check("resp_err",     err_seen,    64'(err));
      check("read_pulses",  64'(n_rd),   64'(exp_rd));
      check("write_pulses", 64'(n_wr),   64'(exp_wr));
      check("rd_wr_overlap", 64'(n_both), 64'd0);
      if (!err) check("resp_rdata", rdata_seen, exp_rdata);
      if (exp_rd != 0) check("read_addr",  rd_addr, 64'(idx));
      if (exp_wr != 0) begin
         check("write_addr", wr_addr, 64'(idx));
         check("write_data", wr_data, word);
      end
      if (wr && !err) ref_mem[idx] = word;
      check("mem_word", tb_mem[idx], ref_mem[idx]);
   endtask

   initial begin
      logic [63:0] saved;
      int          bad;
      logic [1:0]  sz;
      logic [63:0] a;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_B;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      exp_rdata = '0;
      for (int i = 0; i < MEM_WORDS; i++) preload(i, {$urandom, $urandom});

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_req_ready",  64'(req_ready),  64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_err",   64'(resp_err),   64'd0);
      check("rst_resp_rdata", resp_rdata,      64'd0);
      check("rst_mem_read",   64'(mem_read),   64'd0);
      check("rst_mem_write",  64'(mem_write),  64'd0);
      check("rst_mem_addr",   mem_addr,        64'd0);
      check("rst_mem_wdata",  mem_wdata,       64'd0);
      reset = 1'b0;

      // Signed word loads: upper half of word 5, then lower half with sign bit set.
      preload(5, 64'h0000_0000_8000_0000);
      run_req(1'b0, SZ_W, 1'b0, 64'h2C, 64'd0);
      check("dir_load_w_hi", resp_rdata, 64'h0000_0000_0000_0000);
      run_req(1'b0, SZ_W, 1'b0, 64'h28, 64'd0);
      check("dir_load_w_signed", resp_rdata, 64'hFFFF_FFFF_8000_0000);
      run_req(1'b0, SZ_W, 1'b1, 64'h28, 64'd0);
      check("dir_load_w_unsigned", resp_rdata, 64'h0000_0000_8000_0000);

      // Unsigned byte load.
      preload(5, 64'h1122_3344_5566_7788);
      run_req(1'b0, SZ_B, 1'b1, 64'h2E, 64'd0);
      check("dir_load_b_unsigned", resp_rdata, 64'h22);
      run_req(1'b0, SZ_B, 1'b0, 64'h28, 64'd0);
      check("dir_load_b_signed", resp_rdata, 64'hFFFF_FFFF_FFFF_FF88);

      // Sub-word half store.
      preload(2, 64'hAAAA_AAAA_AAAA_AAAA);
      run_req(1'b1, SZ_H, 1'b0, 64'h14, 64'hFFFF_FFFF_FFFF_1234);
      check("dir_store_h", tb_mem[2], 64'hAAAA_1234_AAAA_AAAA);

      // Misaligned load, dword store at the range boundary, aligned dword load.
      run_req(1'b0, SZ_W, 1'b0, 64'h06, 64'd0);
      run_req(1'b1, SZ_D, 1'b0, 64'h2000, 64'h0123_4567_89AB_CDEF);
      run_req(1'b0, SZ_D, 1'b1, 64'h1FF8, 64'd0);
      run_req(1'b1, SZ_D, 1'b0, 64'h1FF8, 64'hDEAD_BEEF_CAFE_F00D);

      // Reset during CAP of a sub-word store: the word must stay untouched.
      preload(2, 64'hAAAA_AAAA_AAAA_AAAA);
      saved = ref_mem[2];
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = SZ_H;
      req_unsigned = 1'b0; req_addr = 64'h14; req_wdata = 64'h5678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_mem_write",  64'(mem_write),  64'd0);
      check("midrst_resp_valid", 64'(resp_valid), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_req_ready",  64'(req_ready),  64'd1);
      check("midrst_resp_valid", 64'(resp_valid), 64'd0);
      check("midrst_mem_word",   tb_mem[2],       saved);
      check("midrst_resp_rdata", resp_rdata,      64'd0);
      exp_rdata = '0;

      // Randomized requests.
      for (int n = 0; n < 300; n++) begin
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) a = 64'($urandom_range(16'h2000, 16'hFFFF));
         else                            a = 64'($urandom_range(0, 16'h1FFF));
         if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         run_req(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom});
      end

      bad = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
      check("final_mem_sweep", 64'(bad), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
